// File: rtl/display_pkg.sv
// Shared types and helpers for the rolling seven-segment display sequencer.
// The default digit geometry lives here; the top level picks it up as parameter defaults.
package display_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 8;
  localparam int DISP_W     = DIGIT_W * NUM_DIGITS;

  // IDLE holds the buffer, RUN auto-scrolls, DWELL pauses after a full rotation.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DWELL = 2'd2
  } scroll_state_t;

  // Rotate one digit toward the LSB: the lowest digit moves to the top.
  function automatic logic [DISP_W-1:0] rotate_right(input logic [DISP_W-1:0] v);
    return {v[DIGIT_W-1:0], v[DISP_W-1:DIGIT_W]};
  endfunction

  // Rotate one digit toward the MSB: the highest digit moves to the bottom.
  function automatic logic [DISP_W-1:0] rotate_left(input logic [DISP_W-1:0] v);
    return {v[DISP_W-DIGIT_W-1:0], v[DISP_W-1:DISP_W-DIGIT_W]};
  endfunction

endpackage

// File: rtl/scroll_prescaler.sv
// Enable-gated modulo-DIV counter with synchronous clear and a terminal-count tick.
// Used both as the scroll timebase and as the dwell period counter.
module scroll_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Advance on enabled cycles and wrap at DIV-1; clear takes priority and holds
  // the counter at zero, disabled cycles simply hold the current count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/display_scroll_ctrl.sv
// Single-clock sequencer for the 8-digit rolling display: owns the digit buffer,
// the scroll timebase, the load handshake and the rotation position.
// Optional feature macro: SCROLL_DWELL_EN (pause DWELL_STEPS tick periods after
// every full rotation while auto-scrolling).
module display_scroll_ctrl #(
  parameter int DIGIT_W     = display_pkg::DIGIT_W,
  parameter int NUM_DIGITS  = display_pkg::NUM_DIGITS,
  parameter int CLK_DIV     = 50_000_000,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] INIT_VALUE = 32'h2464_6421,
  parameter int DWELL_STEPS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
  output logic                          load_ready,
  input  logic                          run,
  input  logic                          dir,
  input  logic                          step_once,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic                          step_pulse,
  output logic                          wrap_pulse,
  output logic [1:0]                    state
);

  import display_pkg::scroll_state_t, display_pkg::IDLE, display_pkg::RUN, display_pkg::DWELL;

  localparam int W  = DIGIT_W * NUM_DIGITS;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(NUM_DIGITS - 1);

  scroll_state_t state_q, state_d;
  logic [W-1:0]  digits_q;
  logic [PW-1:0] pos_q;
  logic          load_ready_q;
  logic          step_pulse_q;
  logic          wrap_pulse_q;

  logic          load_fire;
  logic          do_step;
  logic          at_last;
  logic          tick;
  logic          dwell_done;
  logic [W-1:0]  rot_lsb;
  logic [W-1:0]  rot_msb;

  // Load handshake: a transfer happens on any edge where load_valid and
  // load_ready are both 1. load_ready never depends on load_valid in the same
  // cycle; it drops for exactly one cycle after each transfer.
  assign load_fire = load_valid && load_ready_q;
  assign at_last   = (pos_q == POS_LAST);
  assign rot_lsb   = {digits_q[DIGIT_W-1:0], digits_q[W-1:DIGIT_W]};
  assign rot_msb   = {digits_q[W-DIGIT_W-1:0], digits_q[W-1:W-DIGIT_W]};

  // Scroll timebase: runs while scrolling or dwelling, forced to zero by a load
  // or whenever the FSM is heading to IDLE.
  scroll_prescaler #(
    .DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (load_fire || (state_d == IDLE)),
    .enable ((state_q == RUN) || (state_q == DWELL)),
    .tick   (tick)
  );

  // Dwell period counter: counts scroll ticks while in DWELL, reset on any exit.
  scroll_prescaler #(
    .DIV (DWELL_STEPS)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_d != DWELL),
    .enable (tick && (state_q == DWELL)),
    .tick   (dwell_done)
  );

  // Next-state and step decision; a load always suppresses a coincident step.
  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
        end else if (step_once && !load_fire) begin
          do_step = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
        end else if (tick && !load_fire) begin
          do_step = 1'b1;
`ifdef SCROLL_DWELL_EN
          if (at_last) state_d = DWELL;
`endif
        end
      end
      DWELL: begin
        if (!run) begin
          state_d = IDLE;
        end else if (load_fire || dwell_done) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus buffer, position and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      digits_q     <= INIT_VALUE;
      pos_q        <= '0;
      load_ready_q <= 1'b0;
      step_pulse_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= !load_fire;
      step_pulse_q <= do_step;
      wrap_pulse_q <= do_step && at_last;
      if (load_fire) begin
        digits_q <= load_data;
        pos_q    <= '0;
      end else if (do_step) begin
        digits_q <= dir ? rot_msb : rot_lsb;
        pos_q    <= at_last ? '0 : pos_q + PW'(1);
      end
    end
  end

  assign digits     = digits_q;
  assign load_ready = load_ready_q;
  assign step_pulse = step_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign state      = state_q;

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Directed bench for display_scroll_ctrl with CLK_DIV=4, DWELL_STEPS=2.
// Expected digit values are queued when a step is set up and popped whenever
// the design reports a step_pulse.
module tb_display_scroll_ctrl;

  localparam logic [31:0] INIT = 32'h2464_6421;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        run;
  logic        dir;
  logic        step_once;
  logic [31:0] digits;
  logic        step_pulse;
  logic        wrap_pulse;
  logic [1:0]  state;

  logic [31:0] exp_q[$];
  int          n_chk;
  int          n_fail;
  int          n_steps;
  int          n_wraps;
  int          s0;
  int          w0;
  logic [31:0] m;

  display_scroll_ctrl #(
    .CLK_DIV     (4),
    .DWELL_STEPS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .run        (run),
    .dir        (dir),
    .step_once  (step_once),
    .digits     (digits),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse),
    .state      (state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rot_r(input logic [31:0] x);
    return {x[3:0], x[31:4]};
  endfunction

  function automatic logic [31:0] rot_l(input logic [31:0] x);
    return {x[27:0], x[31:28]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, score any step.
  task automatic cyc();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (wrap_pulse === 1'b1) n_wraps++;
    if (step_pulse === 1'b1) begin
      n_steps++;
      if (exp_q.size() == 0) begin
        chk("unexpected_step", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("step_digits", digits, e);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_steps = 0; n_wraps = 0;
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0;
    run = 1'b0; dir = 1'b0; step_once = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_digits", digits, INIT);
    chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_state", {30'b0, state}, 32'd0);
    chk("rst_step_pulse", {31'b0, step_pulse}, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("ready_after_rst", {31'b0, load_ready}, 32'd1);
    s0 = n_steps;
    repeat (20) cyc();
    chk("idle_no_steps", n_steps - s0, 32'd0);

    // Load, then auto-scroll toward LSB for one full rotation
    load_valid = 1'b1; load_data = 32'h1234_5678;
    cyc();
    chk("load_digits", digits, 32'h1234_5678);
    chk("load_ready_drop", {31'b0, load_ready}, 32'd0);
    load_valid = 1'b0;
    cyc();
    chk("load_ready_back", {31'b0, load_ready}, 32'd1);
    m = 32'h1234_5678;
    for (int i = 0; i < 8; i++) begin
      m = rot_r(m);
      exp_q.push_back(m);
    end
    s0 = n_steps; w0 = n_wraps;
    dir = 1'b0; run = 1'b1;
    repeat (5) cyc();
    chk("first_step_r", digits, 32'h8123_4567);
    repeat (28) cyc();
    chk("full_rot_digits", digits, 32'h1234_5678);
    chk("full_rot_steps", n_steps - s0, 32'd8);
    chk("full_rot_wraps", n_wraps - w0, 32'd1);
    run = 1'b0;
    cyc(); cyc();
    chk("stop_state", {30'b0, state}, 32'd0);

    // Reload, single manual step toward MSB while stopped
    load_valid = 1'b1; load_data = 32'h1234_5678;
    cyc();
    load_valid = 1'b0;
    cyc();
    exp_q.push_back(32'h2345_6781);
    s0 = n_steps;
    dir = 1'b1; step_once = 1'b1;
    cyc();
    step_once = 1'b0;
    repeat (3) cyc();
    chk("step_once_digits", digits, 32'h2345_6781);
    chk("step_once_count", n_steps - s0, 32'd1);

    // step_once held in RUN adds nothing
    exp_q.push_back(32'h3456_7812);
    s0 = n_steps;
    run = 1'b1;
    cyc();
    chk("run_state", {30'b0, state}, 32'd1);
    step_once = 1'b1;
    repeat (4) cyc();
    chk("run_step_once_count", n_steps - s0, 32'd1);
    chk("run_step_l", digits, 32'h3456_7812);
    step_once = 1'b0;

    // Load landing on a tick edge suppresses that step
    repeat (3) cyc();
    s0 = n_steps;
    load_valid = 1'b1; load_data = 32'hABCD_EF01;
    cyc();
    chk("tick_load_digits", digits, 32'hABCD_EF01);
    chk("tick_load_no_step", {31'b0, step_pulse}, 32'd0);
    chk("tick_load_ready", {31'b0, load_ready}, 32'd0);
    load_valid = 1'b0;
    m = rot_l(32'hABCD_EF01);
    exp_q.push_back(m);
    cyc();
    chk("tick_load_ready_back", {31'b0, load_ready}, 32'd1);
    repeat (2) cyc();
    chk("tick_load_gap", n_steps - s0, 32'd0);
    cyc();
    chk("tick_load_next_step", n_steps - s0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      m = rot_l(m);
      exp_q.push_back(m);
    end
    repeat (16) cyc();
    chk("pos5_steps", n_steps - s0, 32'd5);

    // Reset in the middle of RUN
    rst_n = 1'b0;
    cyc();
    chk("midrun_rst_digits", digits, INIT);
    chk("midrun_rst_state", {30'b0, state}, 32'd0);
    chk("midrun_rst_ready", {31'b0, load_ready}, 32'd0);
    chk("midrun_rst_q_empty", exp_q.size(), 32'd0);
    rst_n = 1'b1; run = 1'b0; dir = 1'b0;
    cyc();
    chk("post_rst_ready", {31'b0, load_ready}, 32'd1);

    // Position restarted at 0: wrap only on the 8th step
    m = INIT;
    for (int i = 0; i < 8; i++) begin
      m = rot_r(m);
      exp_q.push_back(m);
    end
    s0 = n_steps; w0 = n_wraps;
    run = 1'b1;
    repeat (29) cyc();
    chk("pos_seven_steps", n_steps - s0, 32'd7);
    chk("pos_no_wrap_yet", n_wraps - w0, 32'd0);
    repeat (4) cyc();
    chk("pos_wrap", n_wraps - w0, 32'd1);
    chk("pos_wrap_digits", digits, INIT);

    // Behaviour right after the wrap
    s0 = n_steps;
    exp_q.push_back(rot_r(INIT));
`ifdef SCROLL_DWELL_EN
    repeat (4) cyc();
    chk("dwell_state", {30'b0, state}, 32'd2);
    repeat (4) cyc();
    chk("dwell_no_steps", n_steps - s0, 32'd0);
    repeat (4) cyc();
    chk("dwell_resume", n_steps - s0, 32'd1);
`else
    repeat (4) cyc();
    chk("no_dwell_step", n_steps - s0, 32'd1);
    chk("no_dwell_state", {30'b0, state}, 32'd1);
`endif

    run = 1'b0;
    cyc(); cyc();
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
